// File: rtl/ttc_chanb_cmd_decoder.sv
// TTC Channel B broadcast command decoder: trigger-reset pulses, staged fill type,
// storage watchdog, saturating unknown-command count and a show-ahead command log.
module ttc_chanb_cmd_decoder #(
    parameter int unsigned CNT_W              = 32,
    parameter int unsigned STORE_TO_W         = 24,
    parameter int unsigned LOG_DEPTH          = 16,
    parameter bit          COMMIT_ON_BOUNDARY = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            brcst,
    input  logic                  brcst_strobe,
    input  logic                  ttc_loopback,
    input  logic                  fill_boundary,
    input  logic [STORE_TO_W-1:0] store_timeout,
    input  logic                  clear_status,
    input  logic [CNT_W-1:0]      thres_unknown_ttc,
    output logic [2:0]            fill_type,
    output logic                  fill_pending,
    output logic                  accept_pulse_triggers,
    output logic                  reset_trig_num,
    output logic                  reset_trig_timestamp,
    output logic [CNT_W-1:0]      unknown_cmd_count,
    output logic                  error_unknown_ttc,
    output logic                  store_timed_out,
    output logic                  log_valid,
    output logic [7:0]            log_data,
    input  logic                  log_ready,
    output logic                  log_overflow
);

    localparam int unsigned PTR_W    = $clog2(LOG_DEPTH);
    localparam int unsigned OCC_W    = $clog2(LOG_DEPTH + 1);
    localparam logic [2:0]  FILL_RST = 3'b001;

    typedef enum logic {
        WD_IDLE   = 1'b0,
        WD_ACTIVE = 1'b1
    } wd_state_e;

    // Command classification; strobes are masked while in loopback
    logic       strobe_v;
    logic       dec_evr;
    logic       dec_cntr;
    logic       dec_fill;
    logic       dec_store;
    logic       dec_unknown;
    logic       store_start;
    logic       store_stop;
    logic [2:0] fill_code;

    always_comb begin
        strobe_v    = brcst_strobe & ~ttc_loopback;
        dec_evr     = strobe_v & brcst[1];
        dec_cntr    = strobe_v & (brcst[7:5] == 3'b001) & brcst[3];
        dec_fill    = strobe_v & brcst[7] & ~brcst[3];
        dec_store   = strobe_v & (brcst[7:6] == 2'b10) & brcst[3];
        dec_unknown = strobe_v & ~dec_cntr & ~dec_fill & ~dec_store & ~brcst[1];
        store_start = dec_store & ~brcst[5];
        store_stop  = dec_store & brcst[5];
        case (brcst[6:5])
            2'b00:   fill_code = 3'b100;
            2'b01:   fill_code = 3'b001;
            2'b10:   fill_code = 3'b010;
            default: fill_code = 3'b011;
        endcase
    end

    // Fill-type staging
    logic [2:0] fill_type_d;
    logic       fill_pending_d;
    logic [2:0] pend_val_q;
    logic [2:0] pend_val_d;

    always_comb begin
        fill_type_d    = fill_type;
        fill_pending_d = fill_pending;
        pend_val_d     = pend_val_q;
        if (COMMIT_ON_BOUNDARY) begin
            // Boundary commits the value staged before this cycle; a same-cycle FILL becomes the new pending
            if (fill_boundary && fill_pending) begin
                fill_type_d    = pend_val_q;
                fill_pending_d = 1'b0;
            end
            if (dec_fill) begin
                pend_val_d     = fill_code;
                fill_pending_d = 1'b1;
            end
        end else if (dec_fill) begin
            fill_type_d = fill_code;
        end
        if (ttc_loopback) begin
            fill_type_d    = FILL_RST;
            fill_pending_d = 1'b0;
            pend_val_d     = FILL_RST;
        end
    end

    // Storage watchdog: accept stays high for store_timeout cycles after a start
    wd_state_e             wd_state_q;
    wd_state_e             wd_state_d;
    logic [STORE_TO_W-1:0] wd_cnt_q;
    logic [STORE_TO_W-1:0] wd_cnt_d;
    logic                  wd_expire;

    always_comb begin
        wd_state_d = wd_state_q;
        wd_cnt_d   = wd_cnt_q;
        wd_expire  = 1'b0;
        case (wd_state_q)
            WD_IDLE: begin
                if (store_start) begin
                    wd_state_d = WD_ACTIVE;
                    wd_cnt_d   = store_timeout;
                end
            end
            WD_ACTIVE: begin
                if (store_start) begin
                    wd_cnt_d = store_timeout;
                end else if (store_stop) begin
                    wd_state_d = WD_IDLE;
                    wd_cnt_d   = '0;
                end else if (store_timeout != '0) begin
                    if (wd_cnt_q <= STORE_TO_W'(1)) begin
                        wd_state_d = WD_IDLE;
                        wd_cnt_d   = '0;
                        wd_expire  = 1'b1;
                    end else begin
                        wd_cnt_d = wd_cnt_q - STORE_TO_W'(1);
                    end
                end
            end
            default: begin
                wd_state_d = WD_IDLE;
                wd_cnt_d   = '0;
            end
        endcase
        if (ttc_loopback) begin
            wd_state_d = WD_IDLE;
            wd_cnt_d   = '0;
            wd_expire  = 1'b0;
        end
    end

    // Status counters and sticky flags; clear_status beats same-cycle sets
    logic [CNT_W-1:0] unknown_cnt_d;
    logic             error_d;
    logic             timed_out_d;
    logic             overflow_d;
    logic             log_drop;

    always_comb begin
        unknown_cnt_d = unknown_cmd_count;
        error_d       = (unknown_cmd_count > thres_unknown_ttc);
        timed_out_d   = store_timed_out | wd_expire;
        overflow_d    = log_overflow | log_drop;
        if (dec_unknown && (unknown_cmd_count != '1)) begin
            unknown_cnt_d = unknown_cmd_count + CNT_W'(1);
        end
        if (clear_status || ttc_loopback) begin
            unknown_cnt_d = '0;
            timed_out_d   = 1'b0;
            overflow_d    = 1'b0;
        end
        if (ttc_loopback) begin
            error_d = 1'b0;
        end
    end

    // Command log FIFO
    logic [7:0]       log_mem [LOG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             log_valid_d;
    logic             log_push;
    logic             log_pop;
    logic             log_full;

    always_comb begin
        log_pop  = log_valid & log_ready;
        log_full = (occ_q == OCC_W'(LOG_DEPTH));
        log_push = strobe_v & (~log_full | log_pop);
        log_drop = strobe_v & log_full & ~log_pop;
        wr_ptr_d = log_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = log_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({log_push, log_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        if (ttc_loopback) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end
        log_valid_d = (occ_d != '0);
    end

    always_ff @(posedge clk) begin
        if (log_push) begin
            log_mem[wr_ptr_q] <= brcst;
        end
    end

    assign log_data = log_mem[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_type             <= FILL_RST;
            fill_pending          <= 1'b0;
            pend_val_q            <= FILL_RST;
            wd_state_q            <= WD_IDLE;
            wd_cnt_q              <= '0;
            accept_pulse_triggers <= 1'b0;
            reset_trig_num        <= 1'b0;
            reset_trig_timestamp  <= 1'b0;
            unknown_cmd_count     <= '0;
            error_unknown_ttc     <= 1'b0;
            store_timed_out       <= 1'b0;
            log_overflow          <= 1'b0;
            wr_ptr_q              <= '0;
            rd_ptr_q              <= '0;
            occ_q                 <= '0;
            log_valid             <= 1'b0;
        end else begin
            fill_type             <= fill_type_d;
            fill_pending          <= fill_pending_d;
            pend_val_q            <= pend_val_d;
            wd_state_q            <= wd_state_d;
            wd_cnt_q              <= wd_cnt_d;
            accept_pulse_triggers <= (wd_state_d == WD_ACTIVE);
            reset_trig_num        <= dec_evr;
            reset_trig_timestamp  <= dec_cntr;
            unknown_cmd_count     <= unknown_cnt_d;
            error_unknown_ttc     <= error_d;
            store_timed_out       <= timed_out_d;
            log_overflow          <= overflow_d;
            wr_ptr_q              <= wr_ptr_d;
            rd_ptr_q              <= rd_ptr_d;
            occ_q                 <= occ_d;
            log_valid             <= log_valid_d;
        end
    end

endmodule

// File: tb/tb_ttc_chanb_cmd_decoder.sv
// Bench for ttc_chanb_cmd_decoder: directed scenarios plus random traffic against a
// cycle-level reference model (boundary-commit instance and immediate-commit instance).
`timescale 1ns/1ps
module tb_ttc_chanb_cmd_decoder;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned STW   = 8;
    localparam int unsigned LD    = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [7:0]       brcst;
    logic             brcst_strobe;
    logic             ttc_loopback;
    logic             fill_boundary;
    logic [STW-1:0]   store_timeout;
    logic             clear_status;
    logic [CNT_W-1:0] thres;
    logic             log_ready;

    logic [2:0]       fill_type,  fill_type_b;
    logic             fill_pending, fill_pending_b;
    logic             accept, accept_b;
    logic             tnum, tnum_b, tts, tts_b;
    logic [CNT_W-1:0] ucnt, ucnt_b;
    logic             err, err_b, sto, sto_b;
    logic             log_valid, log_valid_b;
    logic [7:0]       log_data, log_data_b;
    logic             log_ovf, log_ovf_b;

    always #5 clk = ~clk;

    ttc_chanb_cmd_decoder #(.CNT_W(CNT_W), .STORE_TO_W(STW), .LOG_DEPTH(LD), .COMMIT_ON_BOUNDARY(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .brcst(brcst), .brcst_strobe(brcst_strobe),
        .ttc_loopback(ttc_loopback), .fill_boundary(fill_boundary), .store_timeout(store_timeout),
        .clear_status(clear_status), .thres_unknown_ttc(thres), .fill_type(fill_type),
        .fill_pending(fill_pending), .accept_pulse_triggers(accept), .reset_trig_num(tnum),
        .reset_trig_timestamp(tts), .unknown_cmd_count(ucnt), .error_unknown_ttc(err),
        .store_timed_out(sto), .log_valid(log_valid), .log_data(log_data),
        .log_ready(log_ready), .log_overflow(log_ovf));

    ttc_chanb_cmd_decoder #(.CNT_W(CNT_W), .LOG_DEPTH(LD), .COMMIT_ON_BOUNDARY(1'b0)) dut_imm (
        .clk(clk), .reset_n(reset_n), .brcst(brcst), .brcst_strobe(brcst_strobe),
        .ttc_loopback(ttc_loopback), .fill_boundary(fill_boundary), .store_timeout(24'(store_timeout)),
        .clear_status(clear_status), .thres_unknown_ttc(thres), .fill_type(fill_type_b),
        .fill_pending(fill_pending_b), .accept_pulse_triggers(accept_b), .reset_trig_num(tnum_b),
        .reset_trig_timestamp(tts_b), .unknown_cmd_count(ucnt_b), .error_unknown_ttc(err_b),
        .store_timed_out(sto_b), .log_valid(log_valid_b), .log_data(log_data_b),
        .log_ready(log_ready), .log_overflow(log_ovf_b));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [2:0] m_fill, m_fill_imm, m_pend_val;
    bit         m_pend, m_accept, m_tnum, m_tts, m_err, m_to, m_ovf;
    int         m_cnt, m_edge, m_start;
    logic [7:0] m_log [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    function automatic logic [2:0] fill_code(input logic [1:0] c);
        case (c)
            2'b00:   return 3'b100;
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            default: return 3'b011;
        endcase
    endfunction

    task automatic model_reset();
        m_fill = 3'b001; m_fill_imm = 3'b001; m_pend_val = 3'b001;
        m_pend = 0; m_accept = 0; m_tnum = 0; m_tts = 0; m_err = 0; m_to = 0; m_ovf = 0;
        m_cnt = 0; m_start = 0;
        m_log.delete();
    endtask

    // Predict the state after the coming rising edge from the inputs now applied
    task automatic model_step();
        bit s, cntr, fill, store, unk, pop, full, set_to, set_ovf, new_err;
        m_edge++;
        if (ttc_loopback) begin
            model_reset();
            return;
        end
        s     = brcst_strobe;
        cntr  = s && brcst[7:5] == 3'b001 && brcst[3];
        fill  = s && brcst[7] && !brcst[3];
        store = s && brcst[7:6] == 2'b10 && brcst[3];
        unk   = s && !cntr && !fill && !store && !brcst[1];
        m_tnum = s && brcst[1];
        m_tts  = cntr;

        if (fill_boundary && m_pend) begin
            m_fill = m_pend_val;
            m_pend = 0;
        end
        if (fill) begin
            m_pend_val = fill_code(brcst[6:5]);
            m_pend     = 1;
            m_fill_imm = fill_code(brcst[6:5]);
        end

        set_to = 0;
        if (store && !brcst[5]) begin
            m_accept = 1;
            m_start  = m_edge;
        end else if (store && brcst[5]) begin
            m_accept = 0;
        end else if (m_accept && store_timeout != 0 && (m_edge - m_start) >= int'(store_timeout)) begin
            m_accept = 0;
            set_to   = 1;
        end

        new_err = (m_cnt > int'(thres));
        if (clear_status) m_cnt = 0;
        else if (unk && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        m_err = new_err;
        m_to  = clear_status ? 0 : (m_to | set_to);

        pop     = (m_log.size() > 0) && log_ready;
        full    = (m_log.size() == LD);
        set_ovf = 0;
        if (pop) void'(m_log.pop_front());
        if (s) begin
            if (full && !pop) set_ovf = 1;
            else m_log.push_back(brcst);
        end
        m_ovf = clear_status ? 0 : (m_ovf | set_ovf);
    endtask

    task automatic compare_all();
        chk("fill_type",    32'(fill_type),    32'(m_fill));
        chk("fill_pending", 32'(fill_pending), 32'(m_pend));
        chk("accept",       32'(accept),       32'(m_accept));
        chk("trig_num",     32'(tnum),         32'(m_tnum));
        chk("trig_ts",      32'(tts),          32'(m_tts));
        chk("unknown_cnt",  32'(ucnt),         32'(m_cnt));
        chk("error_unk",    32'(err),          32'(m_err));
        chk("timed_out",    32'(sto),          32'(m_to));
        chk("log_valid",    32'(log_valid),    32'(m_log.size() > 0));
        if (m_log.size() > 0) chk("log_data", 32'(log_data), 32'(m_log[0]));
        chk("log_ovf",      32'(log_ovf),      32'(m_ovf));
        chk("imm_fill_type",    32'(fill_type_b),    32'(m_fill_imm));
        chk("imm_fill_pending", 32'(fill_pending_b), 32'(0));
        chk("imm_accept",       32'(accept_b),       32'(m_accept));
        chk("imm_unknown_cnt",  32'(ucnt_b),         32'(m_cnt));
        chk("imm_log_valid",    32'(log_valid_b),    32'(m_log.size() > 0));
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [7:0] b);
        brcst = b; brcst_strobe = 1'b1;
        tick();
        brcst_strobe = 1'b0;
    endtask

    task automatic rand_segment(input int unsigned to, input int n);
        ttc_loopback = 1'b1; store_timeout = STW'(to);
        tick();
        ttc_loopback = 1'b0;
        for (int i = 0; i < n; i++) begin
            brcst_strobe  = ($urandom % 2) == 0;
            brcst         = 8'($urandom);
            fill_boundary = ($urandom % 10) == 0;
            clear_status  = ($urandom % 40) == 0;
            ttc_loopback  = ($urandom % 150) == 0;
            thres         = CNT_W'($urandom);
            log_ready     = ((i / 64) % 3 != 0) ? (($urandom % 4) != 0) : 1'b0;
            tick();
        end
        brcst_strobe = 0; fill_boundary = 0; clear_status = 0; ttc_loopback = 0; log_ready = 1;
    endtask

    initial begin
        int len;
        reset_n = 0; brcst = 0; brcst_strobe = 0; ttc_loopback = 0; fill_boundary = 0;
        store_timeout = 0; clear_status = 0; thres = 0; log_ready = 0; m_edge = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_fill_type", 32'(fill_type), 32'(3'b001));
        chk("rst_accept",    32'(accept),    32'(0));
        chk("rst_log_valid", 32'(log_valid), 32'(0));
        reset_n = 1;
        tick();

        // EVR pulse, counter-reset pulse, logging
        send(8'h02);
        chk("evr_pulse", 32'(tnum), 32'(1));
        chk("evr_not_unknown", 32'(ucnt), 32'(0));
        chk("evr_logged", 32'(log_data), 32'(8'h02));
        tick();
        chk("evr_pulse_end", 32'(tnum), 32'(0));
        send(8'h28);
        chk("cntr_pulse", 32'(tts), 32'(1));
        log_ready = 1;
        repeat (3) tick();

        // Staged fill type
        send(8'hC0);
        send(8'hE0);
        repeat (2) tick();
        chk("fill_held", 32'(fill_type), 32'(3'b001));
        chk("fill_pend", 32'(fill_pending), 32'(1));
        chk("imm_fill", 32'(fill_type_b), 32'(3'b011));
        fill_boundary = 1; tick(); fill_boundary = 0;
        chk("fill_commit", 32'(fill_type), 32'(3'b011));
        chk("fill_pend_clr", 32'(fill_pending), 32'(0));
        send(8'h80);
        fill_boundary = 1; send(8'hA0); fill_boundary = 0;
        chk("fill_same_cycle", 32'(fill_type), 32'(3'b100));
        chk("fill_same_pend", 32'(fill_pending), 32'(1));
        fill_boundary = 1; tick(); fill_boundary = 0;
        chk("fill_commit2", 32'(fill_type), 32'(3'b001));

        // Storage watchdog
        store_timeout = 5;
        send(8'h88);
        len = accept ? 1 : 0;
        repeat (10) begin
            tick();
            if (accept) len++;
        end
        chk("wd_window_len", 32'(len), 32'(5));
        chk("wd_timed_out", 32'(sto), 32'(1));
        clear_status = 1; tick(); clear_status = 0;
        chk("wd_clear", 32'(sto), 32'(0));
        send(8'h88); tick(); tick(); send(8'hA8);
        chk("wd_stop", 32'(accept), 32'(0));
        repeat (6) tick();
        chk("wd_stop_no_to", 32'(sto), 32'(0));
        send(8'h88); repeat (4) tick(); send(8'hA8);
        chk("wd_stop_at_expiry", 32'(sto), 32'(0));

        // Unknown counter, threshold, saturation
        thres = 2;
        repeat (3) send(8'h00);
        chk("unk_count3", 32'(ucnt), 32'(3));
        chk("unk_err_lag", 32'(err), 32'(0));
        tick();
        chk("unk_err", 32'(err), 32'(1));
        clear_status = 1; tick(); clear_status = 0;
        chk("unk_clear", 32'(ucnt), 32'(0));
        tick();
        chk("unk_err_clear", 32'(err), 32'(0));
        repeat (17) send(8'h00);
        chk("unk_sat", 32'(ucnt), 32'((1 << CNT_W) - 1));
        send(8'h00);
        chk("unk_sat_hold", 32'(ucnt), 32'((1 << CNT_W) - 1));

        // Log overflow and ordering
        ttc_loopback = 1; tick(); ttc_loopback = 0;
        log_ready = 0;
        for (int i = 0; i < 17; i++) send(8'(8'h40 + i));
        chk("log_overflow", 32'(log_ovf), 32'(1));
        for (int i = 0; i < 16; i++) begin
            chk("log_order", 32'(log_data), 32'(8'(8'h40 + i)));
            log_ready = 1; tick(); log_ready = 0;
        end
        chk("log_drained", 32'(log_valid), 32'(0));
        clear_status = 1; tick(); clear_status = 0;
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("log_full_no_ovf", 32'(log_ovf), 32'(0));
        log_ready = 1; send(8'h77); log_ready = 0;
        chk("log_push_pop_full", 32'(log_ovf), 32'(0));
        log_ready = 1;
        repeat (20) tick();

        // Async reset mid-window, loopback mid-pending-fill
        store_timeout = 20;
        send(8'h88);
        repeat (3) tick();
        chk("pre_reset_accept", 32'(accept), 32'(1));
        reset_n = 0;
        #2;
        chk("async_rst_accept", 32'(accept), 32'(0));
        chk("async_rst_fill", 32'(fill_type), 32'(3'b001));
        model_reset();
        @(negedge clk);
        compare_all();
        reset_n = 1;
        tick();
        send(8'hC0);
        chk("lb_pre_pend", 32'(fill_pending), 32'(1));
        ttc_loopback = 1; brcst = 8'hE0; brcst_strobe = 1;
        tick();
        ttc_loopback = 0; brcst_strobe = 0;
        chk("lb_pend", 32'(fill_pending), 32'(0));
        chk("lb_fill", 32'(fill_type), 32'(3'b001));
        chk("lb_log", 32'(log_valid), 32'(0));
        chk("lb_imm_fill", 32'(fill_type_b), 32'(3'b001));
        tick();

        // Random traffic
        rand_segment(3, 800);
        rand_segment(0, 600);
        rand_segment($urandom_range(1, 12), 800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
